// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of memory_controller.
// Registers the granted request, waits for mem_ready or a timeout, and returns data to the winner.
module mem_arbiter #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [DATA_W-1:0] TIMEOUT_RDATA = 32'hDEAD_BEEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_read,
  input  logic              m0_write,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_ready,
  output logic              m0_err,
  input  logic              m1_read,
  input  logic              m1_write,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_ready,
  output logic              m1_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              busy,
  output logic              grant_id
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state;
  logic               last_grant;
  logic [CNT_W-1:0]   cnt;

  logic               req0, req1;
  logic               sel;
  logic               sel_write;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Tie goes to the port that did not win last; a lone requester always wins.
  always_comb begin
    req0      = m0_read | m0_write;
    req1      = m1_read | m1_write;
    sel       = (req0 && req1) ? ~last_grant : req1;
    sel_write = sel ? m1_write : m0_write;
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      m0_rdata   <= '0;
      m0_ready   <= 1'b0;
      m0_err     <= 1'b0;
      m1_rdata   <= '0;
      m1_ready   <= 1'b0;
      m1_err     <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            mem_addr   <= sel_addr;
            mem_wdata  <= sel_wdata;
            mem_write  <= sel_write;
            mem_read   <= ~sel_write;
            grant_id   <= sel;
            last_grant <= sel;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (mem_ready) begin
            if (grant_id) begin
              m1_rdata <= mem_rdata;
              m1_ready <= 1'b1;
              m1_err   <= 1'b0;
            end else begin
              m0_rdata <= mem_rdata;
              m0_ready <= 1'b1;
              m0_err   <= 1'b0;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else if (TIMEOUT_CYCLES != 0 && cnt == CNT_LAST) begin
            if (grant_id) begin
              m1_rdata <= TIMEOUT_RDATA;
              m1_ready <= 1'b1;
              m1_err   <= 1'b1;
            end else begin
              m0_rdata <= TIMEOUT_RDATA;
              m0_ready <= 1'b1;
              m0_err   <= 1'b1;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          m0_ready <= 1'b0;
          m0_err   <= 1'b0;
          m1_ready <= 1'b0;
          m1_err   <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
